// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the iterative divider
package div_pkg;

    localparam int N_REG     = 32;
    localparam int DIV_ITERS = 32;
    localparam int CNT_W     = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_if.sv
// rtl/div_if.sv - start/operand/result handshake between execute stage and divider
interface div_if;
    import div_pkg::*;

    logic             i_divsigned;
    logic [N_REG-1:0] i_dividend;
    logic [N_REG-1:0] i_divisor;
    logic             i_divstart;
    logic             i_cancel;
    logic             o_div_ready;
    logic             o_div_done;
    logic [N_REG-1:0] o_quotient;
    logic [N_REG-1:0] o_remainder;

    modport master (
        output i_divsigned, i_dividend, i_divisor, i_divstart, i_cancel,
        input  o_div_ready, o_div_done, o_quotient, o_remainder
    );

    modport slave (
        input  i_divsigned, i_dividend, i_divisor, i_divstart, i_cancel,
        output o_div_ready, o_div_done, o_quotient, o_remainder
    );

endinterface

// File: rtl/div_unit.sv
// rtl/div_unit.sv - radix-2 restoring divider, one quotient bit per cycle, DIV/DIVU
module div_unit
    import div_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_rst_n,
    div_if.slave  dif
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_ITERS - 1);

    function automatic logic [N_REG-1:0] neg_if(input logic neg, input logic [N_REG-1:0] v);
        return neg ? (~v + 1'b1) : v;
    endfunction

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_REG-1:0] rem_q, rem_d;
    logic [N_REG-1:0] dvd_q, dvd_d;
    logic [N_REG-1:0] dvs_q, dvs_d;
    logic [N_REG-1:0] quo_q, quo_d;
    logic [N_REG-1:0] rmd_q, rmd_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;

    logic [N_REG:0]   partial;
    logic [N_REG:0]   diff;
    logic [N_REG-1:0] rem_next;
    logic [N_REG-1:0] dvd_next;

    // Quotient bits shift into the low end of the dividend register as its MSBs are consumed.
    always_comb begin
        partial = {rem_q, dvd_q[N_REG-1]};
        diff    = partial - {1'b0, dvs_q};
        if (diff[N_REG]) begin
            rem_next = partial[N_REG-1:0];
            dvd_next = {dvd_q[N_REG-2:0], 1'b0};
        end else begin
            rem_next = diff[N_REG-1:0];
            dvd_next = {dvd_q[N_REG-2:0], 1'b1};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;

        case (state_q)
            IDLE: begin
                if (dif.i_divstart && !dif.i_cancel) begin
                    if (dif.i_divisor == '0) begin
                        state_d = DONE;
                        quo_d   = '0;
                        rmd_d   = '0;
                    end else begin
                        state_d = CALC;
                        cnt_d   = '0;
                        rem_d   = '0;
                        dvd_d   = neg_if(dif.i_divsigned & dif.i_dividend[N_REG-1], dif.i_dividend);
                        dvs_d   = neg_if(dif.i_divsigned & dif.i_divisor[N_REG-1], dif.i_divisor);
                        q_neg_d = dif.i_divsigned & (dif.i_dividend[N_REG-1] ^ dif.i_divisor[N_REG-1]);
                        r_neg_d = dif.i_divsigned & dif.i_dividend[N_REG-1];
                    end
                end
            end
            CALC: begin
                rem_d = rem_next;
                dvd_d = dvd_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                    quo_d   = neg_if(q_neg_q, dvd_next);
                    rmd_d   = neg_if(r_neg_q, rem_next);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (dif.i_cancel) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    // Status flags are registered copies of the next state so they read 0 while in reset.
    assign ready_d = (state_d == IDLE);
    assign done_d  = (state_d == DONE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign dif.o_div_ready = ready_q;
    assign dif.o_div_done  = done_q;
    assign dif.o_quotient  = quo_q;
    assign dif.o_remainder = rmd_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit against an arithmetic reference
module tb_div_unit;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    div_if dif();

    div_unit dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .dif     (dif)
    );

    always #5 clk = ~clk;

    function automatic void ref_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
        longint sa, sb;
        if (b == 32'd0) begin
            q = 32'd0;
            r = 32'd0;
            return;
        end
        sa = s ? longint'($signed(a)) : longint'({32'd0, a});
        sb = s ? longint'($signed(b)) : longint'({32'd0, b});
        q  = 32'(sa / sb);
        r  = 32'(sa % sb);
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Launch from a ready cycle; returns at the negedge of the done cycle (or after the budget).
    task automatic run_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r,
                           output int lat, output bit ready_seen, output bit got);
        dif.i_divsigned = s;
        dif.i_dividend  = a;
        dif.i_divisor   = b;
        dif.i_divstart  = 1'b1;
        next_cycle();
        dif.i_divstart  = 1'b0;
        got = 0; ready_seen = 0; lat = 0; q = '0; r = '0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (dif.o_div_done) begin
                got = 1; lat = c; q = dif.o_quotient; r = dif.o_remainder;
                break;
            end
            if (dif.o_div_ready) ready_seen = 1;
            next_cycle();
        end
    endtask

    task automatic test_reset();
        dif.i_divsigned = 0; dif.i_dividend = '0; dif.i_divisor = '0;
        dif.i_divstart = 0; dif.i_cancel = 0;
        #12;
        checks++; if (dif.o_div_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", dif.o_div_ready); end
        checks++; if (dif.o_div_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", dif.o_div_done); end
        checks++; if (dif.o_quotient !== 32'd0) begin errors++; $display("FAIL reset_q got %h want 0", dif.o_quotient); end
        checks++; if (dif.o_remainder !== 32'd0) begin errors++; $display("FAIL reset_r got %h want 0", dif.o_remainder); end
        #5 rst_n = 1'b1;
        next_cycle();
        checks++; if (dif.o_div_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b want 1", dif.o_div_ready); end
        checks++; if (dif.o_div_done !== 1'b0) begin errors++; $display("FAIL post_reset_done got %b want 0", dif.o_div_done); end
    endtask

    task automatic test_directed();
        bit          ts[6] = '{0, 1, 1, 1, 0, 0};
        logic [31:0] ta[6] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] tb[6] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF};
        logic [31:0] tq[6] = '{32'd14, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] tr[6] = '{32'd2, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'h8000_0000};
        logic [31:0] q, r;
        int lat;
        bit rs, got;
        for (int i = 0; i < 6; i++) begin
            run_div(ts[i], ta[i], tb[i], q, r, lat, rs, got);
            checks++; if (!got) begin errors++; $display("FAIL directed_timeout[%0d] got no done want done", i); end
            checks++; if (lat != 33) begin errors++; $display("FAIL directed_latency[%0d] got %0d want 33", i, lat); end
            checks++; if (rs) begin errors++; $display("FAIL directed_ready_busy[%0d] got ready=1 want 0 during cycles 1-33", i); end
            checks++; if (q !== tq[i]) begin errors++; $display("FAIL directed_q[%0d] got %h want %h", i, q, tq[i]); end
            checks++; if (r !== tr[i]) begin errors++; $display("FAIL directed_r[%0d] got %h want %h", i, r, tr[i]); end
            next_cycle();
            checks++; if (dif.o_div_ready !== 1'b1 || dif.o_div_done !== 1'b0) begin
                errors++; $display("FAIL directed_ready_after[%0d] got ready=%b done=%b want 1/0", i, dif.o_div_ready, dif.o_div_done);
            end
        end
    endtask

    task automatic test_divzero();
        logic [31:0] q, r;
        int lat;
        bit rs, got;
        for (int s = 0; s < 2; s++) begin
            run_div(s[0], $urandom | 32'h10, 32'd0, q, r, lat, rs, got);
            checks++; if (!got || lat != 1) begin errors++; $display("FAIL divzero_latency[%0d] got %0d want 1", s, lat); end
            checks++; if (q !== 32'd0 || r !== 32'd0) begin errors++; $display("FAIL divzero_result[%0d] got q=%h r=%h want 0/0", s, q, r); end
            next_cycle();
            checks++; if (dif.o_div_ready !== 1'b1) begin errors++; $display("FAIL divzero_ready[%0d] got %b want 1", s, dif.o_div_ready); end
            run_div(1'b0, 32'd9, 32'd4, q, r, lat, rs, got);
            checks++; if (q !== 32'd2 || r !== 32'd1) begin errors++; $display("FAIL divzero_follow[%0d] got q=%h r=%h want 2/1", s, q, r); end
            next_cycle();
        end
    endtask

    task automatic test_cancel();
        logic [31:0] q, r;
        int lat;
        bit rs, got, saw_done, not_ready;
        saw_done = 0;
        dif.i_divsigned = 0; dif.i_dividend = 32'd1000; dif.i_divisor = 32'd3; dif.i_divstart = 1;
        next_cycle();
        dif.i_divstart = 0;
        for (int c = 1; c < 10; c++) begin
            @(negedge clk);
            if (dif.o_div_done) saw_done = 1;
            next_cycle();
        end
        dif.i_cancel = 1'b1;
        next_cycle();
        dif.i_cancel = 1'b0;
        @(negedge clk);
        checks++; if (dif.o_div_ready !== 1'b1) begin errors++; $display("FAIL cancel_ready got %b want 1 in cycle 11", dif.o_div_ready); end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (dif.o_div_done) saw_done = 1;
        end
        checks++; if (saw_done) begin errors++; $display("FAIL cancel_no_done got done pulse want none"); end
        next_cycle();
        run_div(1'b0, 32'd1000, 32'd3, q, r, lat, rs, got);
        checks++; if (!got || q !== 32'd333 || r !== 32'd1) begin errors++; $display("FAIL cancel_restart got q=%h r=%h want 14d/1", q, r); end
        next_cycle();
        dif.i_divisor = 32'd5; dif.i_divstart = 1'b1; dif.i_cancel = 1'b1;
        next_cycle();
        dif.i_divstart = 1'b0; dif.i_cancel = 1'b0;
        saw_done = 0; not_ready = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (dif.o_div_done) saw_done = 1;
            if (!dif.o_div_ready) not_ready = 1;
        end
        checks++; if (saw_done || not_ready) begin errors++; $display("FAIL cancel_start_same got done=%b busy=%b want 0/0", saw_done, not_ready); end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        logic [31:0] q, r;
        int lat;
        bit rs, got;
        dif.i_divsigned = 1; dif.i_dividend = 32'hFFFF_0123; dif.i_divisor = 32'd77; dif.i_divstart = 1;
        next_cycle();
        dif.i_divstart = 0;
        for (int c = 1; c < 15; c++) next_cycle();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (dif.o_div_ready !== 1'b0 || dif.o_div_done !== 1'b0) begin
            errors++; $display("FAIL midreset_flags got ready=%b done=%b want 0/0", dif.o_div_ready, dif.o_div_done);
        end
        checks++; if (dif.o_quotient !== 32'd0 || dif.o_remainder !== 32'd0) begin
            errors++; $display("FAIL midreset_data got q=%h r=%h want 0/0", dif.o_quotient, dif.o_remainder);
        end
        #3 rst_n = 1'b1;
        next_cycle();
        checks++; if (dif.o_div_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready got %b want 1", dif.o_div_ready); end
        run_div(1'b1, 32'hFFFF_FF9C, 32'd7, q, r, lat, rs, got);
        checks++; if (q !== 32'hFFFF_FFF2 || r !== 32'hFFFF_FFFE) begin errors++; $display("FAIL midreset_follow got q=%h r=%h want fffffff2/fffffffe", q, r); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, q, r, eq, er;
        int lat;
        bit rs, got;
        for (int i = 0; i < 3; i++) begin
            a = $urandom; b = $urandom_range(1, 5000);
            ref_div(i[0], a, b, eq, er);
            run_div(i[0], a, b, q, r, lat, rs, got);
            checks++; if (!got || q !== eq || r !== er) begin errors++; $display("FAIL b2b[%0d] got q=%h r=%h want %h/%h", i, q, r, eq, er); end
            next_cycle();
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, q, r, eq, er;
        int lat, elat;
        bit s, rs, got;
        for (int i = 0; i < 30; i++) begin
            s = 1'($urandom);
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = $urandom_range(1, 15);
                2: b = 32'd0;
                default: b = 32'hFFFF_FFFF - $urandom_range(0, 20);
            endcase
            ref_div(s, a, b, eq, er);
            elat = (b == 32'd0) ? 1 : 33;
            run_div(s, a, b, q, r, lat, rs, got);
            checks++; if (!got || lat != elat) begin errors++; $display("FAIL rand_latency[%0d] got %0d want %0d", i, lat, elat); end
            checks++; if (q !== eq || r !== er) begin
                errors++; $display("FAIL rand_result[%0d] s=%0d a=%h b=%h got q=%h r=%h want %h/%h", i, s, a, b, q, r, eq, er);
            end
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_divzero();
        test_cancel();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
